fetch_unit: RTL and testbench

Instruction-fetch stage: owns the program counter, drives the word address into the instruction memory, and latches the returned 32-bit instruction with its PC into the IF/ID pipeline register. It sits directly upstream of the combinational instruction memory (8-bit word address in, 32-bit instruction out, zero-latency read) and feeds the decode stage. It supports stall, branch/jump redirect with flush, and halt detection.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, the NOP encoding, the halt opcode field and the fetch state enum.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [5:0]        HALT_OPCODE = 6'b111111;
  localparam logic [ADDR_W-1:0] RESET_PC    = 8'd0;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_instr(input logic [DATA_W-1:0] instr,
                                         input logic [5:0] halt_opc);
    return instr[OPC_HI:OPC_LO] == halt_opc;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, decode-side controls and IF/ID outputs.
// Controls: stall holds PC and IF/ID; redirect (with redirect_pc) loads a new PC and flushes IF/ID, taking priority over stall.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc_next;
  logic              if_id_valid;
  logic              halted;
  fetch_state_t      dbg_state;

  modport master (
    output imem_addr, if_id_instr, if_id_pc, if_id_pc_next, if_id_valid, halted, dbg_state,
    input  imem_instr, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc, if_id_pc_next, if_id_valid, halted, dbg_state,
    output imem_instr, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush and hold.
// Flush clears valid and the instruction but keeps the PC fields as they were.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [ADDR_W-1:0] d_pc,
  output logic [DATA_W-1:0] q_instr,
  output logic [ADDR_W-1:0] q_pc,
  output logic [ADDR_W-1:0] q_pc_next,
  output logic              q_valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_instr   <= NOP_INSTR;
      q_pc      <= '0;
      q_pc_next <= '0;
      q_valid   <= 1'b0;
    end else if (flush) begin
      q_instr <= NOP_INSTR;
      q_valid <= 1'b0;
    end else if (load) begin
      q_instr   <= d_instr;
      q_pc      <= d_pc;
      q_pc_next <= d_pc + ADDR_W'(1);
      q_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, RUN/HALT control and the IF/ID register.
// The memory address is the PC register itself; the memory read is combinational.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC_P    = RESET_PC,
  parameter logic [5:0]        HALT_OPCODE_P = HALT_OPCODE
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc;
  fetch_state_t      state;
  logic              halted_q;
  logic              fetch_is_halt;
  logic              ifid_load;
  logic              ifid_flush;

  assign fetch_is_halt = is_halt_instr(bus.imem_instr, HALT_OPCODE_P);

  // Redirect beats everything; HALT keeps flushing so the halt instruction shows for one cycle only.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (bus.redirect || state == HALT) begin
      ifid_flush = 1'b1;
    end else if (!bus.stall) begin
      ifid_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC_P;
      state    <= RUN;
      halted_q <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= bus.redirect_pc;
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!bus.stall) begin
            if (fetch_is_halt) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .d_instr   (bus.imem_instr),
    .d_pc      (pc),
    .q_instr   (bus.if_id_instr),
    .q_pc      (bus.if_id_pc),
    .q_pc_next (bus.if_id_pc_next),
    .q_valid   (bus.if_id_valid)
  );

  assign bus.imem_addr = pc;
  assign bus.halted    = halted_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for fetch/stall/redirect/wrap,
// then hand-written sequences for halt and reset corner cases.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational instruction memory model
  logic [DATA_W-1:0] mem [256];
  assign bus.imem_instr = mem[bus.imem_addr];

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 | {24'h0, a};
  endfunction

  typedef struct {
    logic              rst_n;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] rpc;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc;
    logic [ADDR_W-1:0] e_pcn;
    logic              e_valid;
    logic              e_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver: apply inputs for one edge, then sample 1 time unit after it
  task automatic step(input logic r, input logic s, input logic rd, input logic [ADDR_W-1:0] rpc);
    rst_n           = r;
    bus.stall       = s;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] instr, input logic [ADDR_W-1:0] pc,
                            input logic [ADDR_W-1:0] pcn, input logic valid, input logic hlt);
    check({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(addr));
    check({tag, ".if_id_instr"}, bus.if_id_instr, instr);
    check({tag, ".if_id_pc"}, 32'(bus.if_id_pc), 32'(pc));
    check({tag, ".if_id_pc_next"}, 32'(bus.if_id_pc_next), 32'(pcn));
    check({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(valid));
    check({tag, ".halted"}, 32'(bus.halted), 32'(hlt));
    check({tag, ".state"}, 32'(bus.dbg_state), hlt ? 32'(HALT) : 32'(RUN));
  endtask

  function automatic vec_t mk(input logic s, input logic rd, input logic [ADDR_W-1:0] rpc,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] i,
                              input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] pn,
                              input logic v);
    vec_t t;
    t.rst_n = 1'b1; t.stall = s; t.redirect = rd; t.rpc = rpc;
    t.e_addr = a; t.e_instr = i; t.e_pc = p; t.e_pcn = pn; t.e_valid = v; t.e_halted = 1'b0;
    return t;
  endfunction

  localparam logic [DATA_W-1:0] HALT_WORD = 32'hFC00_0000;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) mem[i] = word_at(8'(i));

    // free run 0..5, stall at PC=3, redirect to 40 with stall, wrap through FF
    vecs.push_back(mk(0, 0, 8'h00, 8'h01, word_at(8'h00), 8'h00, 8'h01, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h02, word_at(8'h01), 8'h01, 8'h02, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h03, word_at(8'h02), 8'h02, 8'h03, 1));
    vecs.push_back(mk(1, 0, 8'h00, 8'h03, word_at(8'h02), 8'h02, 8'h03, 1));
    vecs.push_back(mk(1, 0, 8'h00, 8'h03, word_at(8'h02), 8'h02, 8'h03, 1));
    vecs.push_back(mk(1, 0, 8'h00, 8'h03, word_at(8'h02), 8'h02, 8'h03, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h04, word_at(8'h03), 8'h03, 8'h04, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h05, word_at(8'h04), 8'h04, 8'h05, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h06, word_at(8'h05), 8'h05, 8'h06, 1));
    vecs.push_back(mk(1, 1, 8'h40, 8'h40, NOP_INSTR,      8'h05, 8'h06, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h41, word_at(8'h40), 8'h40, 8'h41, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h42, word_at(8'h41), 8'h41, 8'h42, 1));
    vecs.push_back(mk(0, 1, 8'hFE, 8'hFE, NOP_INSTR,      8'h41, 8'h42, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'hFF, word_at(8'hFE), 8'hFE, 8'hFF, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, word_at(8'hFF), 8'hFF, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h01, word_at(8'h00), 8'h00, 8'h01, 1));

    // reset state, with redirect asserted to show reset wins
    step(1'b0, 1'b0, 1'b1, 8'h77);
    expect_out("reset", 8'h00, NOP_INSTR, 8'h00, 8'h00, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].stall, vecs[k].redirect, vecs[k].rpc);
      expect_out($sformatf("vec%0d", k), vecs[k].e_addr, vecs[k].e_instr,
                 vecs[k].e_pc, vecs[k].e_pcn, vecs[k].e_valid, vecs[k].e_halted);
    end

    // halt at address 4
    mem[4] = HALT_WORD;
    step(1, 0, 1, 8'h02);
    expect_out("h_redir", 8'h02, NOP_INSTR, 8'h00, 8'h01, 0, 0);
    step(1, 0, 0, 8'h00);
    expect_out("h_f2", 8'h03, word_at(8'h02), 8'h02, 8'h03, 1, 0);
    step(1, 0, 0, 8'h00);
    expect_out("h_f3", 8'h04, word_at(8'h03), 8'h03, 8'h04, 1, 0);
    step(1, 0, 0, 8'h00);
    expect_out("h_cap", 8'h04, HALT_WORD, 8'h04, 8'h05, 1, 1);
    step(1, 0, 0, 8'h00);
    expect_out("h_idle", 8'h04, NOP_INSTR, 8'h04, 8'h05, 0, 1);
    step(1, 1, 0, 8'h00);
    expect_out("h_stall", 8'h04, NOP_INSTR, 8'h04, 8'h05, 0, 1);
    step(1, 0, 1, 8'h00);
    expect_out("h_resume", 8'h00, NOP_INSTR, 8'h04, 8'h05, 0, 0);
    step(1, 0, 0, 8'h00);
    expect_out("h_run", 8'h01, word_at(8'h00), 8'h00, 8'h01, 1, 0);

    // halt word under stall is not taken; redirect discards a halt at imem_addr
    step(1, 0, 1, 8'h04);
    expect_out("hs_redir", 8'h04, NOP_INSTR, 8'h00, 8'h01, 0, 0);
    step(1, 1, 0, 8'h00);
    expect_out("hs_stall", 8'h04, NOP_INSTR, 8'h00, 8'h01, 0, 0);
    step(1, 0, 1, 8'h06);
    expect_out("hs_discard", 8'h06, NOP_INSTR, 8'h00, 8'h01, 0, 0);

    // reset while halted
    step(1, 0, 1, 8'h04);
    step(1, 0, 0, 8'h00);
    expect_out("rh_halt", 8'h04, HALT_WORD, 8'h04, 8'h05, 1, 1);
    step(0, 0, 0, 8'h00);
    expect_out("rh_reset", 8'h00, NOP_INSTR, 8'h00, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00);
    expect_out("rh_run", 8'h01, word_at(8'h00), 8'h00, 8'h01, 1, 0);

    // reset during a redirect bubble
    step(1, 0, 1, 8'h80);
    expect_out("rb_bubble", 8'h80, NOP_INSTR, 8'h00, 8'h01, 0, 0);
    step(0, 0, 0, 8'h00);
    expect_out("rb_reset", 8'h00, NOP_INSTR, 8'h00, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00);
    expect_out("rb_run", 8'h01, word_at(8'h00), 8'h00, 8'h01, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
